// File: rtl/ntm_vector_adder_sequencer.sv
// Element-serial vector adder: requests a/b operand pairs, emits c[i] = a[i] + b[i] with index.
// Define NTM_VECTOR_ADDER_SATURATE_EN to clamp carried results to all ones instead of wrapping.
module ntm_vector_adder_sequencer #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned INDEX_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [INDEX_SIZE-1:0] size_in,
  output logic                  data_in_request,
  input  logic                  data_a_in_enable,
  input  logic [DATA_SIZE-1:0]  data_a_in,
  input  logic                  data_b_in_enable,
  input  logic [DATA_SIZE-1:0]  data_b_in,
  output logic                  data_out_enable,
  output logic [DATA_SIZE-1:0]  data_out,
  output logic [INDEX_SIZE-1:0] index_out,
  output logic                  overflow
);

  typedef enum logic [1:0] {StIdle, StInput, StAdd} state_e;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  req_q, req_d;
  logic                  out_en_q, out_en_d;
  logic [DATA_SIZE-1:0]  data_out_q, data_out_d;
  logic [INDEX_SIZE-1:0] index_out_q, index_out_d;
  logic                  overflow_q, overflow_d;
  logic [INDEX_SIZE-1:0] size_q, size_d;
  logic [INDEX_SIZE-1:0] idx_q, idx_d;
  logic [DATA_SIZE-1:0]  a_q, a_d, b_q, b_d;
  logic                  a_vld_q, a_vld_d, b_vld_q, b_vld_d;

  logic [DATA_SIZE-1:0]  a_op, b_op, result;
  logic [DATA_SIZE:0]    sum;

  // Operands as they stand after this cycle's capture, so the result can be
  // registered on the same edge that completes the pair.
  assign a_op = data_a_in_enable ? data_a_in : a_q;
  assign b_op = data_b_in_enable ? data_b_in : b_q;
  assign sum  = {1'b0, a_op} + {1'b0, b_op};

  always_comb begin
`ifdef NTM_VECTOR_ADDER_SATURATE_EN
    result = sum[DATA_SIZE] ? '1 : sum[DATA_SIZE-1:0];
`else
    result = sum[DATA_SIZE-1:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    req_d       = 1'b0;
    out_en_d    = 1'b0;
    data_out_d  = data_out_q;
    index_out_d = index_out_q;
    overflow_d  = overflow_q;
    size_d      = size_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    a_vld_d     = a_vld_q;
    b_vld_d     = b_vld_q;

    case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (start) begin
          size_d     = size_in;
          idx_d      = '0;
          overflow_d = 1'b0;
          ready_d    = 1'b0;
          if (size_in != '0) begin
            state_d = StInput;
            req_d   = 1'b1;
          end
        end
      end

      StInput: begin
        a_d     = a_op;
        b_d     = b_op;
        a_vld_d = a_vld_q | data_a_in_enable;
        b_vld_d = b_vld_q | data_b_in_enable;
        if (a_vld_d && b_vld_d) begin
          state_d     = StAdd;
          data_out_d  = result;
          index_out_d = idx_q;
          out_en_d    = 1'b1;
          overflow_d  = overflow_q | sum[DATA_SIZE];
          a_vld_d     = 1'b0;
          b_vld_d     = 1'b0;
        end
      end

      StAdd: begin
        if (idx_q == size_q - INDEX_SIZE'(1)) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          idx_d   = idx_q + INDEX_SIZE'(1);
          state_d = StInput;
          req_d   = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      ready_q     <= 1'b1;
      req_q       <= 1'b0;
      out_en_q    <= 1'b0;
      data_out_q  <= '0;
      index_out_q <= '0;
      overflow_q  <= 1'b0;
      size_q      <= '0;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      a_vld_q     <= 1'b0;
      b_vld_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      req_q       <= req_d;
      out_en_q    <= out_en_d;
      data_out_q  <= data_out_d;
      index_out_q <= index_out_d;
      overflow_q  <= overflow_d;
      size_q      <= size_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_vld_q     <= a_vld_d;
      b_vld_q     <= b_vld_d;
    end
  end

  assign ready           = ready_q;
  assign data_in_request = req_q;
  assign data_out_enable = out_en_q;
  assign data_out        = data_out_q;
  assign index_out       = index_out_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_ntm_vector_adder_sequencer.sv
// Randomized bench for ntm_vector_adder_sequencer: drives operand pairs per request and checks
// each result against a queue of expected (cycle, index, value, overflow) entries.
module tb_ntm_vector_adder_sequencer;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          ready;
  logic [IW-1:0] size_in = '0;
  logic          data_in_request;
  logic          data_a_in_enable = 1'b0;
  logic [DW-1:0] data_a_in = '0;
  logic          data_b_in_enable = 1'b0;
  logic [DW-1:0] data_b_in = '0;
  logic          data_out_enable;
  logic [DW-1:0] data_out;
  logic [IW-1:0] index_out;
  logic          overflow;

  ntm_vector_adder_sequencer #(.DATA_SIZE(DW), .INDEX_SIZE(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .ready            (ready),
    .size_in          (size_in),
    .data_in_request  (data_in_request),
    .data_a_in_enable (data_a_in_enable),
    .data_a_in        (data_a_in),
    .data_b_in_enable (data_b_in_enable),
    .data_b_in        (data_b_in),
    .data_out_enable  (data_out_enable),
    .data_out         (data_out),
    .index_out        (index_out),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int idx; int val; int ovf;} exp_t;
  exp_t exp_q[$];
  exp_t cur_e;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int req_cnt = 0;
  int last_out_cyc = 0;
  int got_val[256];
  int vec_ovf = 0;
  int cur_idx = 0;
  bit noise_en = 1'b0;
  int t_req;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Reference result of one element: true sum, then wrap or clamp.
  function automatic int model_val(input int a, input int b);
    int s;
    s = a + b;
`ifdef NTM_VECTOR_ADDER_SATURATE_EN
    if (s >= (1 << DW)) return (1 << DW) - 1;
`endif
    return s % (1 << DW);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_in_request) req_cnt++;
    if (data_out_enable) begin
      last_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got data_out=%0d index=%0d expected none at cycle %0d",
                 data_out, index_out, cyc);
      end else begin
        cur_e = exp_q.pop_front();
        check("out_cycle", cyc, cur_e.cyc);
        check("data_out", int'(data_out), cur_e.val);
        check("index_out", int'(index_out), cur_e.idx);
        check("overflow", int'(overflow), cur_e.ovf);
        got_val[cur_e.idx] = int'(data_out);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      cur_e = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missing_output: got nothing expected index %0d by cycle %0d",
               cur_e.idx, cur_e.cyc);
    end
  end

  task automatic idle_cycle();
    if (noise_en && $urandom_range(0, 1) == 1) begin
      start   = 1'b1;
      size_in = IW'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_ab(input bit ae, input int av, input bit be, input int bv);
    data_a_in_enable = ae;
    data_a_in        = DW'(av);
    data_b_in_enable = be;
    data_b_in        = DW'(bv);
    @(negedge clk);
    data_a_in_enable = 1'b0;
    data_b_in_enable = 1'b0;
    data_a_in        = DW'($urandom);
    data_b_in        = DW'($urandom);
  endtask

  task automatic push_exp(input int a, input int b);
    if (a + b >= (1 << DW)) vec_ovf = 1;
    exp_q.push_back('{cyc + 1, cur_idx, model_val(a, b), vec_ovf});
  endtask

  // Deliver one element; the pair completes on the last drive, result due one cycle later.
  task automatic deliver(input int a, input int b, input int mode, input int delay,
                         input int gap, input int junk_a, input bit junk_add);
    repeat (delay) idle_cycle();
    case (mode)
      0: begin
        push_exp(a, b);
        drive_ab(1'b1, a, 1'b1, b);
      end
      1: begin
        drive_ab(1'b1, a, 1'b0, 0);
        repeat (gap - 1) idle_cycle();
        push_exp(a, b);
        drive_ab(1'b0, 0, 1'b1, b);
      end
      2: begin
        drive_ab(1'b0, 0, 1'b1, b);
        repeat (gap - 1) idle_cycle();
        push_exp(a, b);
        drive_ab(1'b1, a, 1'b0, 0);
      end
      default: begin
        drive_ab(1'b1, junk_a, 1'b0, 0);
        repeat (gap - 1) idle_cycle();
        drive_ab(1'b1, a, 1'b0, 0);
        push_exp(a, b);
        drive_ab(1'b0, 0, 1'b1, b);
      end
    endcase
    // Enables during the result cycle must be ignored.
    if (junk_add) begin
      data_a_in_enable = 1'b1;
      data_b_in_enable = 1'b1;
    end
    @(negedge clk);
    data_a_in_enable = 1'b0;
    data_b_in_enable = 1'b0;
    cur_idx++;
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!data_in_request && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!data_in_request) begin
      n_checks++;
      n_errors++;
      $display("FAIL request_timeout: got no request expected one for index %0d", cur_idx);
    end
  endtask

  task automatic start_vec(input int size);
    data_a_in_enable = 1'b1;
    data_b_in_enable = 1'b1;
    data_a_in        = DW'($urandom);
    data_b_in        = DW'($urandom);
    @(negedge clk);
    data_a_in_enable = 1'b0;
    data_b_in_enable = 1'b0;
    req_cnt = 0;
    vec_ovf = 0;
    cur_idx = 0;
    start   = 1'b1;
    size_in = IW'(size);
    @(negedge clk);
    start   = 1'b0;
    size_in = IW'($urandom);
    check("ready_after_start", int'(ready), 0);
    check("overflow_after_start", int'(overflow), 0);
  endtask

  task automatic finish_vec(input int size);
    check("ready_after_last", int'(ready), 1);
    check("request_count", req_cnt, size);
    check("pending_outputs", exp_q.size(), 0);
    check("overflow_final", int'(overflow), vec_ovf);
  endtask

  task automatic check_reset();
    check("rst_ready", int'(ready), 1);
    check("rst_request", int'(data_in_request), 0);
    check("rst_out_enable", int'(data_out_enable), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_index_out", int'(index_out), 0);
    check("rst_overflow", int'(overflow), 0);
  endtask

  task automatic run_random_vector();
    int size;
    int a;
    int b;
    size = $urandom_range(1, 6);
    start_vec(size);
    for (int i = 0; i < size; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 255);
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 255);
      wait_req();
      deliver(a, b, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(1, 3),
              $urandom_range(0, 255), 1'($urandom_range(0, 1)));
    end
    finish_vec(size);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b1;

    // Three elements, both operands together.
    start_vec(3);
    for (int i = 0; i < 3; i++) begin
      wait_req();
      deliver(i + 1, 10 * (i + 1), 0, 0, 1, 0, 1'b0);
    end
    finish_vec(3);
    check("t1_c0", got_val[0], 11);
    check("t1_c1", got_val[1], 22);
    check("t1_c2", got_val[2], 33);

    // a at t, b at t+3, result at t+4.
    start_vec(1);
    wait_req();
    t_req = cyc;
    deliver(200, 100, 1, 0, 3, 0, 1'b0);
    finish_vec(1);
    check("t2_latency", last_out_cyc - t_req, 4);
`ifdef NTM_VECTOR_ADDER_SATURATE_EN
    check("t2_value", got_val[0], 255);
`else
    check("t2_value", got_val[0], 44);
`endif
    check("t2_overflow", int'(overflow), 1);

    // Zero-length vector: ready low one cycle, nothing else.
    start_vec(0);
    @(negedge clk);
    check("t3_ready_back", int'(ready), 1);
    check("t3_requests", req_cnt, 0);

    // Overwritten operand plus ignored start/enable noise.
    noise_en = 1'b1;
    start_vec(2);
    wait_req();
    deliver(7, 1, 3, 0, 1, 5, 1'b1);
    wait_req();
    deliver(3, 4, 0, 2, 1, 0, 1'b1);
    finish_vec(2);
    check("t4_c0", got_val[0], 8);
    check("t4_c1", got_val[1], 7);
    noise_en = 1'b0;

    // Reset after element 1 of a four-element vector.
    start_vec(4);
    for (int i = 0; i < 2; i++) begin
      wait_req();
      deliver(i + 3, i + 4, 0, 0, 1, 0, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_quiet_ready", int'(ready), 1);
    start_vec(1);
    wait_req();
    deliver(0, 0, 0, 0, 1, 0, 1'b0);
    finish_vec(1);
    check("t5_c0", got_val[0], 0);
    check("t5_index", int'(index_out), 0);

    // Overflowing vector followed by a clean one.
    start_vec(1);
    wait_req();
    deliver(255, 1, 0, 0, 1, 0, 1'b0);
    finish_vec(1);
    check("t6_overflow_first", int'(overflow), 1);
    start_vec(1);
    wait_req();
    deliver(1, 1, 0, 0, 1, 0, 1'b0);
    finish_vec(1);
    check("t6_overflow_second", int'(overflow), 0);
    check("t6_c0", got_val[0], 2);

    noise_en = 1'b1;
    repeat (25) run_random_vector();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
